mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single Memory port (rd_en/wr_en/addr/data/ack) between two requesters.
- Port 0 is the Core; port 1 is a loader/debug master.
- Round-robin arbitration, one outstanding transaction at a time, and an ack timeout so a missing Memory ack cannot hang a requester.
- Sits between Core/loader and Memory inside the top level.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address bus width.
- TIMEOUT, 16, cycles to wait for mem_ack_i after the strobe before an error completion (>=2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_i  in  1  port 0 request; held until ack0_o.
- we0_i  in  1  port 0 write (1) / read (0).
- addr0_i  in  ADDR_W  port 0 address.
- wdata0_i  in  DATA_W  port 0 write data.
- rdata0_o  out  DATA_W  port 0 read data; valid while ack0_o=1.
- ack0_o  out  1  port 0 completion, one-cycle pulse.
- err0_o  out  1  port 0 timeout flag, only with ack0_o.
- req1_i, we1_i, addr1_i, wdata1_i, rdata1_o, ack1_o, err1_o: same as port 0, for port 1.
- mem_rd_en_o  out  1  Memory read strobe.
- mem_wr_en_o  out  1  Memory write strobe.
- mem_addr_o  out  ADDR_W  Memory address.
- mem_data_o  out  DATA_W  Memory write data.
- mem_data_i  in  DATA_W  Memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  Memory completion.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - State IDLE; all outputs 0; rdata0_o and rdata1_o = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - Timeout counter = 0.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the port that is not last_grant.
  - On grant, latch id, we, addr and wdata into internal registers, then go to ISSUE.
  - mem_ack_i is ignored in IDLE.
- ISSUE (exactly one cycle):
  - Assert mem_rd_en_o (we=0) or mem_wr_en_o (we=1).
  - mem_addr_o and mem_data_o driven from the latched registers.
  - If mem_ack_i=1 this cycle, go to RESP; otherwise go to WAIT.
- WAIT:
  - Strobes low; addr and data held.
  - Counter increments each cycle.
  - On mem_ack_i=1, go to RESP.
  - If the counter reaches TIMEOUT-1 without ack, go to RESP with the error flag set.
- Capture on the transition into RESP:
  - Read with ack: capture mem_data_i into the winner's rdata register.
  - Write, or timeout: rdata is unchanged, except that a read timeout loads 0.
  - Update last_grant to the winner.
  - Clear the counter.
- RESP (one cycle):
  - Pulse ackN_o for the winner; errN_o=1 if timed out.
  - The other port's ack and err stay 0.
  - Go to IDLE.
  - The requester drops or changes req on the edge after it sees ack; IDLE samples the new value, so there is no double grant.
- Latency: req sampled in IDLE at cycle n → strobe at n+1 → with zero-wait Memory ack at n+1, ackN_o at n+2. Minimum 3 cycles per transaction including IDLE.
- Timeout case: ackN_o asserts TIMEOUT+1 cycles after the strobe cycle (strobe at n+1, ackN_o/errN_o at n+TIMEOUT+2).
- Back-to-back with both req held: grants alternate 0,1,0,1 with no idle cycles beyond the mandatory IDLE.
- Requests and input changes outside IDLE are ignored; latched values are used.
- A late mem_ack_i after a timeout arrives in RESP or IDLE and is ignored.
- rst mid-operation:
  - Next state IDLE; strobes and acks drop the cycle after rst is sampled.
  - No completion pulse is generated for the aborted transaction.
  - last_grant=1; counter=0; rdata registers=0.
- mem_rd_en_o and mem_wr_en_o are never high together, and never high outside ISSUE.

Test Plan:
- Port 0 only, read addr 0x10, Memory acks in the strobe cycle with 0xCAFEF00D → mem_rd_en_o for 1 cycle with mem_addr_o=0x10; ack0_o 1 cycle later with rdata0_o=0xCAFEF00D; ack1_o stays 0.
- Port 1 write addr 0x20 data 0x12345678, ack after 3 wait cycles → mem_wr_en_o pulse with mem_data_o=0x12345678; ack1_o 1 cycle after mem_ack_i; err1_o=0; rdata1_o unchanged.
- Both ports request continuously from reset, 4 transactions → grant order 0,1,0,1; each requester receives exactly 2 acks.
- Memory never acks, TIMEOUT=16, port 0 read → ack0_o and err0_o both high exactly 17 cycles after the strobe; rdata0_o=0; a later mem_ack_i in IDLE is ignored.
- rst asserted during WAIT → busy_o=0 and strobes 0 the next cycle; no ack or err pulse; the next simultaneous request is granted to port 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the two requester ports and the shared Memory port of mem_port_arbiter.
// slave is the arbiter's view; master is the environment (Core, loader and Memory).
interface mem_port_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              req0_i;
   logic              we0_i;
   logic [ADDR_W-1:0] addr0_i;
   logic [DATA_W-1:0] wdata0_i;
   logic [DATA_W-1:0] rdata0_o;
   logic              ack0_o;
   logic              err0_o;

   logic              req1_i;
   logic              we1_i;
   logic [ADDR_W-1:0] addr1_i;
   logic [DATA_W-1:0] wdata1_i;
   logic [DATA_W-1:0] rdata1_o;
   logic              ack1_o;
   logic              err1_o;

   logic              mem_rd_en_o;
   logic              mem_wr_en_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic [DATA_W-1:0] mem_data_i;
   logic              mem_ack_i;
   logic              busy_o;

   modport slave (
      input  req0_i, we0_i, addr0_i, wdata0_i,
      input  req1_i, we1_i, addr1_i, wdata1_i,
      input  mem_data_i, mem_ack_i,
      output rdata0_o, ack0_o, err0_o,
      output rdata1_o, ack1_o, err1_o,
      output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o, busy_o
   );

   modport master (
      output req0_i, we0_i, addr0_i, wdata0_i,
      output req1_i, we1_i, addr1_i, wdata1_i,
      output mem_data_i, mem_ack_i,
      input  rdata0_o, ack0_o, err0_o,
      input  rdata1_o, ack1_o, err1_o,
      input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o, busy_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one Memory port between the Core (port 0) and a
// loader/debug master (port 1), one transaction at a time, with an ack timeout.
module mem_port_arbiter #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;

   logic              grant;
   logic              grant_id;
   logic              timeout;

   logic              id_q;
   logic              we_q;
   logic              last_grant_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              we_d;
   logic              rd_en_d;
   logic              wr_en_d;
   logic              ack0_d;
   logic              ack1_d;
   logic              err0_d;
   logic              err1_d;
   logic              busy_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic [DATA_W-1:0] capture_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: round-robin grant in IDLE, ack-or-timeout exit from WAIT
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_id   = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req0_i || bus.req1_i) begin
               grant      = 1'b1;
               grant_id   = bus.req1_i && (!bus.req0_i || !last_grant_q);
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next = bus.mem_ack_i ? RESP : WAIT;
         end
         WAIT: begin
            if (bus.mem_ack_i) begin
               state_next = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_next = RESP;
               timeout    = 1'b1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode: next values of every registered output
   always_comb begin
      we_d    = we_q;
      addr_d  = bus.mem_addr_o;
      wdata_d = bus.mem_data_o;
      if (grant) begin
         we_d    = grant_id ? bus.we1_i    : bus.we0_i;
         addr_d  = grant_id ? bus.addr1_i  : bus.addr0_i;
         wdata_d = grant_id ? bus.wdata1_i : bus.wdata0_i;
      end
      rd_en_d   = (state_next == ISSUE) && !we_d;
      wr_en_d   = (state_next == ISSUE) && we_d;
      ack0_d    = (state_next == RESP) && !id_q;
      ack1_d    = (state_next == RESP) && id_q;
      err0_d    = timeout && !id_q;
      err1_d    = timeout && id_q;
      busy_d    = (state_next != IDLE);
      capture_d = timeout ? '0 : bus.mem_data_i;
   end

   // Latched request, counter, read-data capture and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         id_q            <= 1'b0;
         we_q            <= 1'b0;
         last_grant_q    <= 1'b1;
         cnt_q           <= '0;
         bus.mem_rd_en_o <= 1'b0;
         bus.mem_wr_en_o <= 1'b0;
         bus.mem_addr_o  <= '0;
         bus.mem_data_o  <= '0;
         bus.ack0_o      <= 1'b0;
         bus.ack1_o      <= 1'b0;
         bus.err0_o      <= 1'b0;
         bus.err1_o      <= 1'b0;
         bus.rdata0_o    <= '0;
         bus.rdata1_o    <= '0;
         bus.busy_o      <= 1'b0;
      end else begin
         if (grant) begin
            id_q <= grant_id;
         end
         we_q            <= we_d;
         bus.mem_addr_o  <= addr_d;
         bus.mem_data_o  <= wdata_d;
         bus.mem_rd_en_o <= rd_en_d;
         bus.mem_wr_en_o <= wr_en_d;
         bus.ack0_o      <= ack0_d;
         bus.ack1_o      <= ack1_d;
         bus.err0_o      <= err0_d;
         bus.err1_o      <= err1_d;
         bus.busy_o      <= busy_d;
         cnt_q <= (state == WAIT && state_next == WAIT) ? cnt_q + CNT_W'(1) : '0;
         // Writes keep rdata; reads load Memory data, or zero on timeout
         if (state_next == RESP) begin
            last_grant_q <= id_q;
            if (!we_q && !id_q) begin
               bus.rdata0_o <= capture_d;
            end
            if (!we_q && id_q) begin
               bus.rdata1_o <= capture_d;
            end
         end
      end
   end

endmodule
